// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: the push stream, the pop stream, the RAM pin bundle and the
// occupancy status, grouped so the controller and its environment share one bus.
// The master view belongs to the controller (it drives s_ready, m_*, ram_* and
// the status). The slave view belongs to whatever feeds it and hosts the RAM.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        input  s_valid, s_data, m_ready, ram_data_out,
        output s_ready, m_valid, m_data, ram_we, ram_addr, ram_data_in,
               count, full, empty
    );

    modport slave (
        output s_valid, s_data, m_ready, ram_data_out,
        input  s_ready, m_valid, m_data, ram_we, ram_addr, ram_data_in,
               count, full, empty
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port synchronous RAM
// (registered read data). It arbitrates one RAM access per cycle, giving reads
// priority, and exposes the stored bytes through a one-entry output register.
// Optional feature: define RAM_FIFO_BYPASS_EN so that a push into a completely
// drained FIFO loads the output register directly, skipping the RAM round trip.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    ram_fifo_ctrl_if.master bus
);
    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              rd_inflight;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    logic pop;
    logic slot_free;
    logic rd_issue;
    logic full_c;
    logic s_ready_c;
    logic accept;
    logic byp_load;
    logic ram_write;

    // Read/write arbitration: a read is issued whenever the output register will
    // be free when the data comes back; pushes take the port otherwise.
    always_comb begin
        pop       = out_valid && bus.m_ready;
        slot_free = !rd_inflight && (!out_valid || pop);
        rd_issue  = (count != '0) && slot_free;
        full_c    = (count == DEPTH_C);
        s_ready_c = !full_c && !rd_issue;
        accept    = bus.s_valid && s_ready_c && !rst;
`ifdef RAM_FIFO_BYPASS_EN
        // Nothing is stored or in flight ahead of this word, so it may skip the RAM.
        byp_load  = accept && (count == '0) && slot_free;
`else
        byp_load  = 1'b0;
`endif
        ram_write = accept && !byp_load;
    end

    assign bus.s_ready     = s_ready_c;
    assign bus.m_valid     = out_valid;
    assign bus.m_data      = out_data;
    assign bus.ram_we      = ram_write;
    assign bus.ram_addr    = rd_issue ? rd_ptr : wr_ptr;
    assign bus.ram_data_in = bus.s_data;
    assign bus.count       = count;
    assign bus.full        = full_c;
    assign bus.empty       = (count == '0) && !rd_inflight && !out_valid;

    // RAM bookkeeping: pointers wrap naturally at DEPTH; writes and read issue
    // never coincide, so count moves by at most one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ram_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_issue)  rd_ptr <= rd_ptr + PTR_ONE;
            if (ram_write)     count <= count + CNT_ONE;
            else if (rd_issue) count <= count - CNT_ONE;
        end
    end

    // Output register: RAM return data wins (the slot was reserved at issue),
    // then a bypass load, otherwise a pop empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_inflight) begin
                out_data  <= bus.ram_data_out;
                out_valid <= 1'b1;
            end else if (byp_load) begin
                out_data  <= bus.s_data;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: bench for ram_fifo_ctrl with a behavioural 16x8 RAM and a
// queue-based model of FIFO contents that checks order, occupancy and status.
module tb_ram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;
    logic [7:0] q[$];
    int   wr_idx = 0;
    int   pops_total = 0;
    logic [7:0] mem [16];

    ram_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus();

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: write, or registered read, each edge.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data_in;
        else            bus.ram_data_out <= mem[bus.ram_addr];
    end

    // Model of FIFO contents, updated from the handshakes about to happen at the next edge.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rst) begin
                q.delete();
                wr_idx = 0;
            end else begin
                n_checks++;
                if (bus.empty !== (q.size() == 0))
                    $display("FAIL empty: got %b want %b (held %0d)", bus.empty, q.size() == 0, q.size());
                else n_pass++;
                n_checks++;
                if (int'(bus.count) > q.size() || int'(bus.count) + 2 < q.size())
                    $display("FAIL count_range: got %0d want %0d..%0d", bus.count, q.size() - 2, q.size());
                else n_pass++;
                n_checks++;
                if (bus.full !== (bus.count == 5'd16))
                    $display("FAIL full_flag: got %b want %b", bus.full, bus.count == 5'd16);
                else n_pass++;
                if (bus.m_valid === 1'b1) begin
                    n_checks++;
                    if (q.size() == 0)
                        $display("FAIL head: got m_valid=1 m_data=%h want nothing held", bus.m_data);
                    else if (bus.m_data !== q[0])
                        $display("FAIL head: got %h want %h", bus.m_data, q[0]);
                    else n_pass++;
                end
                if (bus.ram_we === 1'b1) begin
                    n_checks++;
                    if (bus.ram_addr !== 4'(wr_idx % 16))
                        $display("FAIL wr_addr: got %0d want %0d", bus.ram_addr, wr_idx % 16);
                    else n_pass++;
                    wr_idx++;
                end
                if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                    if (q.size() != 0) void'(q.pop_front());
                    pops_total++;
                end
                if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) q.push_back(bus.s_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] v);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        #1;
        while (bus.s_ready !== 1'b1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (t >= 20) $display("FAIL push_wait: got s_ready=%b want 1 within 20 cycles", bus.s_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        while (bus.empty !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (bus.empty !== 1'b1) $display("FAIL drain: got empty=%b want 1", bus.empty);
        else n_pass++;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        bus.m_ready = 1'b0;
        cyc();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.full !== 1'b0 ||
            bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.ram_we !== 1'b0)
            $display("FAIL reset: got m_valid=%b m_data=%h full=%b empty=%b count=%0d ram_we=%b want 0 00 0 1 0 0",
                     bus.m_valid, bus.m_data, bus.full, bus.empty, bus.count, bus.ram_we);
        else n_pass++;
        cyc();
        mon_on = 1'b1;
        rst = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_latency();
        cyc();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.m_ready = 1'b1;
        #1;
        n_checks++;
`ifdef RAM_FIFO_BYPASS_EN
        if (bus.ram_we !== 1'b0) $display("FAIL lat_push: got ram_we=%b want 0", bus.ram_we);
        else n_pass++;
`else
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 4'd0)
            $display("FAIL lat_push: got ram_we=%b addr=%0d want 1 0", bus.ram_we, bus.ram_addr);
        else n_pass++;
`endif
        cyc();
        bus.s_valid = 1'b0;
        #1;
`ifdef RAM_FIFO_BYPASS_EN
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5)
            $display("FAIL lat_out: got m_valid=%b m_data=%h want 1 a5", bus.m_valid, bus.m_data);
        else n_pass++;
`else
        n_checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 4'd0 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0)
            $display("FAIL lat_read: got ram_we=%b addr=%0d s_ready=%b m_valid=%b want 0 0 0 0",
                     bus.ram_we, bus.ram_addr, bus.s_ready, bus.m_valid);
        else n_pass++;
        cyc();
        n_checks++;
        if (bus.m_valid !== 1'b0) $display("FAIL lat_e1: got m_valid=%b want 0", bus.m_valid);
        else n_pass++;
        cyc();
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5)
            $display("FAIL lat_out: got m_valid=%b m_data=%h want 1 a5", bus.m_valid, bus.m_data);
        else n_pass++;
`endif
        drain();
    endtask

    task automatic test_fill();
        logic [7:0] got[$];
        int t = 0;
        cyc();
        bus.m_ready = 1'b0;
        for (int v = 0; v < 16; v++) push_one(8'(v));
        repeat (3) cyc();
        n_checks++;
        if (bus.count !== 5'd15 || bus.m_valid !== 1'b1 || bus.m_data !== 8'h00 || bus.full !== 1'b0)
            $display("FAIL fill15: got count=%0d m_valid=%b m_data=%h full=%b want 15 1 00 0",
                     bus.count, bus.m_valid, bus.m_data, bus.full);
        else n_pass++;
        push_one(8'h10);
        #1;
        n_checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.s_ready !== 1'b0)
            $display("FAIL fill16: got count=%0d full=%b s_ready=%b want 16 1 0", bus.count, bus.full, bus.s_ready);
        else n_pass++;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        repeat (3) begin
            #1;
            n_checks++;
            if (bus.ram_we !== 1'b0 || bus.s_ready !== 1'b0)
                $display("FAIL overflow: got ram_we=%b s_ready=%b want 0 0", bus.ram_we, bus.s_ready);
            else n_pass++;
            cyc();
        end
        bus.s_valid = 1'b0;
        n_checks++;
        if (bus.count !== 5'd16) $display("FAIL overflow_count: got %0d want 16", bus.count);
        else n_pass++;
        bus.m_ready = 1'b1;
        while (got.size() < 17 && t < 100) begin
            #1;
            if (bus.m_valid === 1'b1) got.push_back(bus.m_data);
            cyc();
            t++;
        end
        bus.m_ready = 1'b0;
        #1;
        n_checks++;
        if (got.size() != 17) $display("FAIL drain_len: got %0d want 17", got.size());
        else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 8'(i)) $display("FAIL drain_order[%0d]: got %h want %h", i, got[i], 8'(i));
            else n_pass++;
        end
        n_checks++;
        if (bus.empty !== 1'b1) $display("FAIL fill_empty: got %b want 1", bus.empty);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] src[40];
        int sent = 0;
        int t = 0;
        int w0 = wr_idx;
        int p0 = pops_total;
        bit fired;
        for (int i = 0; i < 40; i++) src[i] = 8'($urandom);
        cyc();
        bus.m_ready = 1'b1;
        while (sent < 40 && t < 400) begin
            bus.s_valid = 1'b1;
            bus.s_data  = src[sent];
            #1;
            fired = (bus.s_ready === 1'b1);
            cyc();
            if (fired) sent++;
            t++;
        end
        bus.s_valid = 1'b0;
        drain();
        n_checks++;
        if (pops_total - p0 != 40) $display("FAIL wrap_pops: got %0d want 40", pops_total - p0);
        else n_pass++;
`ifndef RAM_FIFO_BYPASS_EN
        n_checks++;
        if (wr_idx - w0 < 32) $display("FAIL wrap_writes: got %0d want >=32", wr_idx - w0);
        else n_pass++;
`endif
    endtask

    task automatic test_arbitration();
        bit prev_stall = 1'b0;
        bit stall;
        cyc();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(8'($urandom));
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        repeat (40) begin
            bus.s_data = 8'($urandom);
            #1;
            stall = (bus.s_ready === 1'b0) && (bus.full === 1'b0);
            n_checks++;
            if (stall && (bus.ram_we !== 1'b0 || prev_stall))
                $display("FAIL arb_read: got ram_we=%b prev_stall=%b want 0 0", bus.ram_we, prev_stall);
            else if (!stall && bus.ram_we !== 1'b1)
                $display("FAIL arb_write: got ram_we=%b want 1", bus.ram_we);
            else n_pass++;
            prev_stall = stall;
            cyc();
        end
        bus.s_valid = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] a;
        logic [5:0] c0;
        a = 8'($urandom);
        cyc();
        bus.m_ready = 1'b0;
        push_one(a);
        push_one(8'($urandom));
        repeat (3) cyc();
        c0 = bus.count;
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== a || c0 !== 6'd1)
            $display("FAIL bp_start: got m_valid=%b m_data=%h count=%0d want 1 %h 1", bus.m_valid, bus.m_data, c0, a);
        else n_pass++;
        repeat (5) begin
            cyc();
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== a || bus.count !== 5'(c0))
                $display("FAIL bp_hold: got m_valid=%b m_data=%h count=%0d want 1 %h %0d",
                         bus.m_valid, bus.m_data, bus.count, a, c0);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_random();
        cyc();
        repeat (400) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = 8'($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();
    endtask

    task automatic test_reset_mid_read();
        cyc();
        bus.m_ready = 1'b0;
        push_one(8'h3C);
        cyc();
        rst = 1'b1;
        cyc();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1)
            $display("FAIL mid_reset: got m_valid=%b count=%0d empty=%b want 0 0 1", bus.m_valid, bus.count, bus.empty);
        else n_pass++;
        rst = 1'b0;
        repeat (2) cyc();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.empty !== 1'b1)
            $display("FAIL mid_reset_after: got m_valid=%b empty=%b want 0 1", bus.m_valid, bus.empty);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        test_reset();
        test_latency();
        test_fill();
        test_back_to_back();
        test_arbitration();
        test_backpressure();
        test_random();
        test_reset_mid_read();
        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
